// File: rtl/viterbi_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_pkg
// Shared definitions for the K=3, rate-1/2 convolutional encoder and the
// Viterbi decoder: constraint length, generator polynomials (octal 7 / 5),
// tail length and the encoder FSM state type.
// Also provides enc_sym(), the single place where the generator taps are applied.
// -----------------------------------------------------------------------------
package viterbi_pkg;

  localparam int K        = 3;
  localparam int TAIL_LEN = K - 1;

  // Tap masks are ordered {current bit, s[1], s[0]} (newest tap first).
  localparam logic [K-1:0] G0 = 3'o7;
  localparam logic [K-1:0] G1 = 3'o5;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FLUSH
  } fsm_state_t;

  // Coded symbol for input bit b given shift state s (s[1] = most recent bit).
  // Result is {G0 output, G1 output}, matching the decoder's symbol order.
  function automatic logic [1:0] enc_sym(input logic b, input logic [K-2:0] s);
    logic [K-1:0] window;
    window = {b, s};
    return {^(window & G0), ^(window & G1)};
  endfunction

endpackage

// File: rtl/conv_encoder.sv
// -----------------------------------------------------------------------------
// conv_encoder
// Rate-1/2, K=3 convolutional encoder (G0=7, G1=5 octal) with valid/ready
// handshakes on both sides, optional zero-tail termination and a per-frame
// symbol counter. The output symbol is registered (one cycle latency) and a
// new bit can be accepted every cycle while the output register drains.
//
// Parameters
//   TERMINATE  1 = append K-1 zero tail bits after in_last, 0 = no tail
//   CNT_W      width of sym_count
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream info bit valid
//   in_bit     information bit
//   in_last    final info bit of the frame
//   in_ready   encoder accepts the bit this cycle
//   out_valid  out_sym holds a valid coded symbol
//   out_sym    coded symbol, [1] = G0 output, [0] = G1 output
//   out_last   final symbol of the frame (tail included)
//   out_ready  downstream accepts the symbol
//   sym_count  symbols emitted in the current frame (saturating)
// -----------------------------------------------------------------------------
module conv_encoder #(
  parameter int TERMINATE = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [1:0]       out_sym,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] sym_count
);

  import viterbi_pkg::*;

  localparam bit         TERM      = (TERMINATE != 0);
  localparam logic [1:0] LAST_TAIL = 2'(TAIL_LEN - 1);

  fsm_state_t       state;
  logic [K-2:0]     s;
  logic [1:0]       tail_cnt;
  logic             ready_en;

  logic             out_free;
  logic             accept;
  logic [K-2:0]     s_base;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       bit_sym;
  logic [1:0]       tail_sym;

  // ready_en keeps in_ready low until the first clock edge after reset release.
  assign out_free = !out_valid || out_ready;
  assign in_ready = ready_en && (state != FLUSH) && out_free;
  assign accept   = in_valid && in_ready;

  // A bit accepted in IDLE opens a new frame, so it encodes from a cleared
  // shift state and restarts the symbol count instead of using the held values.
  always_comb begin
    s_base   = (state == IDLE) ? '0 : s;
    cnt_base = (state == IDLE) ? '0 : sym_count;
    cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
    bit_sym  = enc_sym(in_bit, s_base);
    tail_sym = enc_sym(1'b0, s);
  end

  // Encoder FSM with registered outputs. A drained output register is cleared
  // first; any load in the same cycle overrides that below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s         <= '0;
      tail_cnt  <= '0;
      ready_en  <= 1'b0;
      out_valid <= 1'b0;
      out_sym   <= '0;
      out_last  <= 1'b0;
      sym_count <= '0;
    end else begin
      ready_en <= 1'b1;

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state)
        IDLE, DATA: begin
          if (accept) begin
            out_sym   <= bit_sym;
            out_valid <= 1'b1;
            sym_count <= cnt_next;
            if (in_last && TERM) begin
              out_last <= 1'b0;
              s        <= {in_bit, s_base[K-2:1]};
              tail_cnt <= '0;
              state    <= FLUSH;
            end else if (in_last) begin
              // Unterminated frame: boundary is here, next frame starts at 00.
              out_last <= 1'b1;
              s        <= '0;
              state    <= IDLE;
            end else begin
              out_last <= 1'b0;
              s        <= {in_bit, s_base[K-2:1]};
              state    <= DATA;
            end
          end
        end

        FLUSH: begin
          if (out_free) begin
            out_sym   <= tail_sym;
            out_valid <= 1'b1;
            sym_count <= cnt_next;
            s         <= {1'b0, s[K-2:1]};
            out_last  <= (tail_cnt == LAST_TAIL);
            if (tail_cnt == LAST_TAIL) begin
              tail_cnt <= '0;
              state    <= IDLE;
            end else begin
              tail_cnt <= tail_cnt + 2'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter TERMINATE, default 1; 1 = append K-1 zero tail bits after in_last, 0 = no tail.
REQ-002 SHALL have parameter CNT_W, default 16; width of the frame symbol counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream info bit is valid.
REQ-006 SHALL have port in_bit  input  1  information bit.
REQ-007 SHALL have port in_last  input  1  marks the final info bit of a frame.
REQ-008 SHALL have port in_ready  output  1  encoder accepts the bit this cycle.
REQ-009 SHALL have port out_valid  output  1  out_sym holds a valid coded symbol.
REQ-010 SHALL have port out_sym  output  2  coded symbol; [1] = G0 output, [0] = G1 output (same bit order as the decoder's received-symbol input).
REQ-011 SHALL have port out_last  output  1  final symbol of the frame, including tail symbols.
REQ-012 SHALL have port out_ready  input  1  downstream (decoder/channel) accepts the symbol.
REQ-013 SHALL have port sym_count  output  CNT_W  number of symbols emitted in the current frame; holds the final value after out_last.

Function
REQ-014 SHALL implement a rate-1/2, K=3 convolutional code with G0 = 7 octal and G1 = 5 octal.
REQ-015 SHALL keep a 2-bit shift state s; s[1] = most recent bit; g0 = b^s[1]^s[0]; g1 = b^s[0]; next s = {b, s[1]}.
REQ-016 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-017 SHALL register the output: the symbol for a bit accepted in cycle N appears on out_sym in cycle N+1 (latency 1).
REQ-018 SHALL drive in_ready = (state == IDLE or DATA) && (!out_valid || out_ready), giving full throughput of 1 symbol/cycle.
REQ-019 SHALL hold out_sym, out_last and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL use FSM states IDLE, DATA, FLUSH.
REQ-021 SHALL, in IDLE, accept a bit: go to DATA; if in_last and TERMINATE=1, go to FLUSH; if in_last and TERMINATE=0, stay in IDLE and assert out_last on that symbol.
REQ-022 SHALL, in DATA, handle an accepted in_last the same way as in REQ-021, otherwise remain in DATA.
REQ-023 SHALL, in FLUSH, deassert in_ready and generate 2 tail symbols with b=0, one per cycle when the output register is free; out_last is set on the second; then return to IDLE with s=00.
REQ-024 SHALL clear s to 00 and sym_count to 0 on the first accepted bit of each new frame; with TERMINATE=0, s SHALL also clear at the frame boundary.
REQ-025 SHALL increment sym_count on each output load and saturate at all-ones.
REQ-026 SHALL allow in_valid to deassert mid-frame (bubbles); state SHALL be held and no symbol generated.
REQ-027 SHALL allow a new frame's first bit to be accepted in the cycle after the last tail symbol loads (back-to-back frames).

Reset
REQ-028 SHALL, while rst_n is low, force: state=IDLE, s=00, out_valid=0, out_sym=00, out_last=0, sym_count=0, in_ready=0.
REQ-029 SHALL, on reset assertion mid-frame or mid-flush, discard the partial frame; no tail symbols are emitted after release.
REQ-030 SHALL allow in_ready to rise no earlier than the first clk edge after rst_n deasserts.

Structure
REQ-031 SHALL place K, G0, G1, the tail length (K-1) and the FSM state enum in the shared package viterbi_pkg, which the decoder also uses.
REQ-032 SHALL be a single module with no sub-modules; the generator polynomials SHALL be a package function, enc_sym(b, s).

Verification
REQ-033 SHALL cover frame 1,0,1,1 (last) with TERMINATE=1 and out_ready=1 -> symbols 11,10,00,01,01,11; out_last only on the 6th; sym_count=6.
REQ-034 SHALL cover the same frame with out_ready low for 3 cycles at symbol 2 -> 10 held stable, in_ready=0, sequence unchanged.
REQ-035 SHALL cover TERMINATE=0 with frame 1,1 (last) -> 11,01 with out_last on 01; the next frame starts from s=00.
REQ-036 SHALL cover two back-to-back frames of 1 (last) -> 11,10,11 then 11,10,11 with no idle cycle between them.
REQ-037 SHALL cover rst_n pulsed low during FLUSH -> out_valid=0 immediately, no remaining tail symbol, and the next frame encodes from s=00.
REQ-038 SHALL cover a loopback with 200 random bits through the Viterbi decoder on an error-free channel -> decoded bits equal the input.
